branch_pc_sequencer: RTL
========================

Name: branch_pc_sequencer

Overview:
- Program-counter and conditional-branch sequencer for the Mini-SRC datapath. It sits directly downstream of the condition flip-flop and consumes its CON output.
- Owns the PC register: increments it on fetch, loads it from the bus for jumps, and resolves conditional branches.
- For a conditional branch it strobes the condition flip-flop, waits for the flag to settle, samples it, then applies PC <= PC + sext(C).

Parameters:
- PC_W, 32, PC and bus width.
- C_W, 19, branch displacement field width (IR[18:0]).
- CON_LAT, 2, cycles between the con_strobe rising edge and a valid con_flag (minimum 1).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock; rising edge active.
- clr  in  1  asynchronous, active-low reset.
- pc_inc  in  1  fetch increment: PC <= PC + 1.
- pc_load  in  1  load PC from bus_in (jr/jal).
- bus_in  in  PC_W  bus value for pc_load.
- br_start  in  1  one-cycle pulse that starts a conditional branch.
- ir  in  32  instruction register; captured on br_start.
- con_flag  in  1  CON output of the condition flip-flop.
- con_ir_bits  out  2  registered IR[20:19] forwarded to the condition flip-flop.
- con_strobe  out  1  CON_In pulse to the condition flip-flop.
- pc  out  PC_W  current PC.
- busy  out  1  high while a branch is in flight.
- br_taken  out  1  result of the last resolved branch; holds until the next resolve.
- br_done  out  1  one-cycle pulse when a branch resolves.

Behaviour:
- Reset (clr low, asynchronous): pc=RESET_PC; state=IDLE; counter=0; con_strobe, busy, br_taken and br_done all 0; con_ir_bits=0.
- FSM states: IDLE, STROBE, WAIT, RESOLVE.
- IDLE:
  - br_start=1: capture C=ir[18:0] and con_ir_bits=ir[20:19], then go to STROBE.
  - Otherwise stay in IDLE.
- STROBE:
  - con_strobe=1 for exactly one cycle; counter=CON_LAT-1.
  - Go to WAIT, or to RESOLVE directly if CON_LAT==1.
- WAIT: decrement counter each cycle; go to RESOLVE when it reaches 0.
- RESOLVE:
  - Sample con_flag into br_taken.
  - If con_flag=1: pc <= pc + sext(C) (signed, bit 18 replicated to PC_W).
  - Pulse br_done, then return to IDLE.
  - br_done is high in the cycle after RESOLVE, together with the updated pc.
- busy=1 in STROBE, WAIT and RESOLVE. Total latency from br_start to br_done is CON_LAT+2 cycles.
- PC arithmetic is modulo 2^PC_W: increment and displacement both wrap silently (0xFFFFFFFF+1=0).
- Priority in the same cycle: clr > pc_load > branch PC update > pc_inc.
  - pc_load while busy: pc <= bus_in and the branch is aborted (return to IDLE, no br_done, br_taken unchanged).
  - pc_inc while busy: ignored, PC is not changed.
  - pc_inc together with br_start in IDLE: the increment applies and the branch starts.
- br_start while busy: ignored.
- con_ir_bits holds its captured value until the next accepted br_start.
- Reset mid-branch: immediate return to IDLE; all outputs take reset values.

Decomposition:
- Shared package (cpu_pkg):
  - FSM state encoding (2-bit localparams).
  - Condition codes: BRZR=2'b00, BRNZ=2'b01, BRPL=2'b10, BRMI=2'b11.
  - Field positions IR_COND_HI/LO=20/19 and IR_C_HI=18.
- Sub-module sext_c19 (combinational sign extender, C_W to PC_W). Everything else stays in one module.

Test Plan:
- Reset then 3 pc_inc pulses: pc=0 -> 1 -> 2 -> 3; busy=0; br_done never asserted.
- pc=0x10, br_start with ir[20:19]=00 and C=0x00005, con_flag=1 at RESOLVE: con_strobe pulses once, br_done CON_LAT+2 cycles after br_start, pc=0x15, br_taken=1.
- pc=0x10, C=0x7FFFE (-2), con_flag=1: pc=0x0E. Repeat with con_flag=0: pc stays 0x10, br_taken=0, br_done still pulses.
- Wrap cases:
  - pc=0xFFFFFFFF with pc_inc: pc=0.
  - pc=0x00000001, C=0x7FFFC (-4), taken: pc=0xFFFFFFFD.
- Simultaneous events:
  - pc_load with bus_in=0x200 during WAIT: pc=0x200, busy=0 next cycle, no br_done.
  - A second br_start while busy: ignored.
  - pc_inc while busy: pc unchanged.
- clr low during STROBE (asynchronous, mid-cycle): pc=RESET_PC, con_strobe=0 and busy=0 immediately. A new branch after release completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared Mini-SRC constants: branch FSM encoding, condition
//               codes and IR field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_STROBE  = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RESOLVE = 2'd3;

    typedef enum logic [1:0] {
        BRZR = 2'b00,
        BRNZ = 2'b01,
        BRPL = 2'b10,
        BRMI = 2'b11
    } br_cond_e;

    localparam int IR_COND_HI = 20;
    localparam int IR_COND_LO = 19;
    localparam int IR_C_HI    = 18;

endpackage
`default_nettype wire

// File: rtl/branch_pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_pc_sequencer_if
// Description : Control/bus bundle between the sequencer, its driver and the
//               condition flip-flop.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_pc_sequencer_if #(
    parameter int PC_W = 32
);
    logic            pc_inc;
    logic            pc_load;
    logic [PC_W-1:0] bus_in;
    logic            br_start;
    logic [31:0]     ir;
    logic            con_flag;
    logic [1:0]      con_ir_bits;
    logic            con_strobe;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            br_taken;
    logic            br_done;

    modport slave (
        input  pc_inc, pc_load, bus_in, br_start, ir, con_flag,
        output con_ir_bits, con_strobe, pc, busy, br_taken, br_done
    );

    modport master (
        output pc_inc, pc_load, bus_in, br_start, ir, con_flag,
        input  con_ir_bits, con_strobe, pc, busy, br_taken, br_done
    );
endinterface
`default_nettype wire

// File: rtl/sext_c19.sv
`default_nettype none
// ============================================================================
// Module      : sext_c19
// Description : Sign-extends the branch displacement field to PC width.
// Revision    : 1.0 - initial release
// ============================================================================
module sext_c19 #(
    parameter int C_W  = 19,
    parameter int PC_W = 32
) (
    input  wire logic [C_W-1:0]  i_c,
    output logic      [PC_W-1:0] o_ext
);
    assign o_ext = {{(PC_W-C_W){i_c[C_W-1]}}, i_c};
endmodule
`default_nettype wire

// File: rtl/branch_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : branch_pc_sequencer
// Description : PC register with fetch increment, bus load and conditional
//               branch resolution against the condition flip-flop.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_pc_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              C_W      = 19,
    parameter int              CON_LAT  = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  wire logic             clk,
    input  wire logic             clr,
    branch_pc_sequencer_if.slave  bus
);
    localparam int CNT_W = (CON_LAT > 1) ? $clog2(CON_LAT) : 1;

    logic [1:0]      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [C_W-1:0]  r_c;
    br_cond_e        r_cond;
    logic [PC_W-1:0] r_pc;
    logic            r_br_taken;
    logic            r_br_done;
    logic [PC_W-1:0] w_disp;
    logic            w_busy;
    logic            w_abort;
    logic            w_unused_ir;

    sext_c19 #(
        .C_W  (C_W),
        .PC_W (PC_W)
    ) u_sext (
        .i_c   (r_c),
        .o_ext (w_disp)
    );

    assign w_busy      = (r_state != S_IDLE);
    assign w_abort     = w_busy && bus.pc_load;
    assign w_unused_ir = ^bus.ir[31:IR_COND_HI+1];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_c        <= '0;
            r_cond     <= BRZR;
            r_pc       <= RESET_PC;
            r_br_taken <= 1'b0;
            r_br_done  <= 1'b0;
        end else begin
            r_br_done <= 1'b0;

            // A bus load wins over everything in flight, including RESOLVE.
            if (w_abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.br_start) begin
                            r_c     <= bus.ir[C_W-1:0];
                            r_cond  <= br_cond_e'(bus.ir[IR_COND_HI:IR_COND_LO]);
                            r_state <= S_STROBE;
                        end
                    end
                    S_STROBE: begin
                        r_cnt   <= CNT_W'(CON_LAT - 1);
                        r_state <= (CON_LAT == 1) ? S_RESOLVE : S_WAIT;
                    end
                    S_WAIT: begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= S_RESOLVE;
                        end
                    end
                    default: begin
                        r_br_taken <= bus.con_flag;
                        r_br_done  <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                endcase
            end

            if (bus.pc_load) begin
                r_pc <= bus.bus_in;
            end else if ((r_state == S_RESOLVE) && bus.con_flag) begin
                r_pc <= r_pc + w_disp;
            end else if (bus.pc_inc && !w_busy) begin
                r_pc <= r_pc + PC_W'(1);
            end
        end
    end

    assign bus.con_ir_bits = r_cond;
    assign bus.con_strobe  = (r_state == S_STROBE);
    assign bus.pc          = r_pc;
    assign bus.busy        = w_busy;
    assign bus.br_taken    = r_br_taken;
    assign bus.br_done     = r_br_done;

endmodule
`default_nettype wire
